// File: rtl/usb_phy_tx.sv
// Full-speed USB transmit serializer: SYNC, LSB-first data, bit stuffing, NRZI,
// abort and EOP, fed from the link byte handshake through a one-byte holding register.
module usb_phy_tx #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_lp_sop,
  input  logic       tx_lp_eop,
  input  logic       tx_lp_valid,
  input  logic [7:0] tx_lp_data,
  input  logic       tx_lp_cancle,
  output logic       tx_lp_ready,
  output logic       dp,
  output logic       dm,
  output logic       tx_oe,
  output logic       tx_underrun
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    ones_q, ones_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          shift_eop_q, shift_eop_d;
  logic          hold_eop_q, hold_eop_d;
  logic          hold_full_q, hold_full_d;
  logic          cancel_q, cancel_d;
  logic          level_q, level_d;
  logic          dp_q, dp_d, dm_q, dm_d;
  logic          oe_q, oe_d, urun_q, urun_d, ready_q, ready_d;

  logic          boundary, accept, store, load, flush, emit, emit_bit, se0;
  logic [2:0]    idx_nxt;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = '0;
    idx_d       = idx_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    shift_eop_d = shift_eop_q;
    hold_d      = hold_q;
    hold_eop_d  = hold_eop_q;
    hold_full_d = hold_full_q;
    cancel_d    = cancel_q;
    level_d     = level_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    oe_d        = oe_q;
    urun_d      = 1'b0;
    boundary    = (bit_cnt_q == BIT_LAST);
    accept      = tx_lp_valid && ready_q;
    store       = accept;
    load        = 1'b0;
    flush       = 1'b0;
    emit        = 1'b0;
    emit_bit    = 1'b1;
    se0         = 1'b0;
    idx_nxt     = idx_q + 3'd1;

    if (state_q != S_IDLE) begin
      bit_cnt_d = boundary ? '0 : bit_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        level_d  = 1'b1;
        cancel_d = 1'b0;
        if (tx_lp_cancle) begin
          flush = 1'b1;
          store = 1'b0;
        end else if (accept && tx_lp_sop) begin
          state_d  = S_SYNC;
          idx_d    = '0;
          oe_d     = 1'b1;
          emit     = 1'b1;
          emit_bit = 1'b0;
        end else begin
          store = 1'b0;
        end
      end
      S_SYNC, S_DATA: begin
        if (tx_lp_cancle) cancel_d = 1'b1;
        if (boundary) begin
          // A pending stuff bit is sent before the byte boundary is handled.
          if (cancel_q || tx_lp_cancle) begin
            state_d  = S_ABORT;
            idx_d    = '0;
            flush    = 1'b1;
            cancel_d = 1'b0;
            emit     = 1'b1;
          end else if (state_q == S_SYNC && idx_q != 3'd7) begin
            idx_d    = idx_nxt;
            emit     = 1'b1;
            emit_bit = (idx_q == 3'd6);
          end else if (state_q == S_DATA && ones_q == 3'd6) begin
            emit     = 1'b1;
            emit_bit = 1'b0;
          end else if (state_q == S_DATA && idx_q != 3'd7) begin
            idx_d    = idx_nxt;
            emit     = 1'b1;
            emit_bit = shift_q[idx_nxt];
          end else if (state_q == S_DATA && shift_eop_q) begin
            state_d = S_EOP;
            idx_d   = '0;
            se0     = 1'b1;
          end else if (hold_full_q) begin
            state_d  = S_DATA;
            load     = 1'b1;
            idx_d    = '0;
            emit     = 1'b1;
            emit_bit = hold_q[0];
          end else begin
            urun_d   = 1'b1;
            state_d  = S_ABORT;
            idx_d    = '0;
            flush    = 1'b1;
            cancel_d = 1'b0;
            emit     = 1'b1;
          end
        end
      end
      S_ABORT: begin
        if (boundary) begin
          if (idx_q == 3'd6) begin
            state_d = S_EOP;
            idx_d   = '0;
            se0     = 1'b1;
          end else begin
            idx_d = idx_nxt;
            emit  = 1'b1;
          end
        end
      end
      S_EOP: begin
        if (boundary) begin
          if (idx_q == 3'd0) begin
            idx_d = idx_nxt;
          end else if (idx_q == 3'd1) begin
            idx_d   = idx_nxt;
            level_d = 1'b1;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            level_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // NRZI: a zero toggles the line; the ones run only counts outside ABORT.
    if (emit) begin
      if (!emit_bit) level_d = !level_d;
      dp_d = level_d;
      dm_d = !level_d;
      if (state_d != S_ABORT) ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
    end
    if (se0) begin
      dp_d = 1'b0;
      dm_d = 1'b0;
    end
    if (load) begin
      shift_d     = hold_q;
      shift_eop_d = hold_eop_q;
      hold_full_d = 1'b0;
    end
    if (store) begin
      hold_d      = tx_lp_data;
      hold_eop_d  = tx_lp_eop;
      hold_full_d = 1'b1;
    end
    if (flush) hold_full_d = 1'b0;

    ready_d = !hold_full_d && (state_d != S_ABORT) && (state_d != S_EOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      shift_eop_q <= 1'b0;
      hold_q      <= '0;
      hold_eop_q  <= 1'b0;
      hold_full_q <= 1'b0;
      cancel_q    <= 1'b0;
      level_q     <= 1'b1;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      oe_q        <= 1'b0;
      urun_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      shift_eop_q <= shift_eop_d;
      hold_q      <= hold_d;
      hold_eop_q  <= hold_eop_d;
      hold_full_q <= hold_full_d;
      cancel_q    <= cancel_d;
      level_q     <= level_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      oe_q        <= oe_d;
      urun_q      <= urun_d;
      ready_q     <= ready_d;
    end
  end

  assign tx_lp_ready = ready_q;
  assign dp          = dp_q;
  assign dm          = dm_q;
  assign tx_oe       = oe_q;
  assign tx_underrun = urun_q;
endmodule

// File: tb/tb_usb_phy_tx.sv
// Randomized packets checked cycle by cycle against a bit-stream model of the
// USB line (SYNC, stuffing, NRZI, abort, EOP) and an NRZI/destuff decoder.
`timescale 1ns/1ps
module tb_usb_phy_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_lp_sop = 1'b0, tx_lp_eop = 1'b0, tx_lp_valid = 1'b0, tx_lp_cancle = 1'b0;
  logic [7:0] tx_lp_data = 8'h00;
  logic       tx_lp_ready, dp, dm, tx_oe, tx_underrun;

  int         checks = 0, errors = 0;
  int         done_cnt = 0, urun_cnt = 0, exp_stuff = 0, dec_stuff = 0;
  logic [7:0] pkt[$];
  logic [7:0] dec[$];
  logic [1:0] cap[$], done_cap[$], exp_sym[$];
  logic       cap_rdy[$], done_rdy[$];
  logic       prev_oe = 1'b0;

  usb_phy_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst),
    .tx_lp_sop(tx_lp_sop), .tx_lp_eop(tx_lp_eop), .tx_lp_valid(tx_lp_valid),
    .tx_lp_data(tx_lp_data), .tx_lp_cancle(tx_lp_cancle), .tx_lp_ready(tx_lp_ready),
    .dp(dp), .dm(dm), .tx_oe(tx_oe), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line monitor: one {dp,dm} sample per cycle while tx_oe is high.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cap.delete();
      cap_rdy.delete();
      prev_oe = 1'b0;
    end else begin
      if (tx_underrun) urun_cnt++;
      if (tx_oe) begin
        cap.push_back({dp, dm});
        cap_rdy.push_back(tx_lp_ready);
      end else if (prev_oe) begin
        done_cap = cap;
        done_rdy = cap_rdy;
        cap.delete();
        cap_rdy.delete();
        done_cnt++;
      end
      prev_oe = tx_oe;
    end
  end

  // Expected symbols per line bit. With abort set, only the first 'keep' line
  // bits survive, followed by seven unstuffed ones.
  task automatic build_exp(input int keep, input bit abort);
    bit   raw[$];
    bit   lb[$];
    int   ones = 0;
    logic lvl = 1'b1;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    foreach (pkt[b]) for (int i = 0; i < 8; i++) raw.push_back(pkt[b][i]);
    exp_stuff = 0;
    foreach (raw[i]) begin
      lb.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lb.push_back(1'b0);
        ones = 0;
        exp_stuff++;
      end
    end
    if (abort) begin
      while (lb.size() > keep) void'(lb.pop_back());
      repeat (7) lb.push_back(1'b1);
    end
    exp_sym.delete();
    foreach (lb[i]) begin
      if (!lb[i]) lvl = !lvl;
      exp_sym.push_back(lvl ? 2'b10 : 2'b01);
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  task automatic decode();
    bit         bits[$];
    logic [1:0] prev = 2'b10;
    logic [1:0] s;
    logic [7:0] cur;
    int         ones = 0;
    dec.delete();
    dec_stuff = 0;
    for (int k = 0; k * CPB + CPB / 2 < done_cap.size(); k++) begin
      s = done_cap[k * CPB + CPB / 2];
      if (s == 2'b00) break;
      if (ones == 6) begin
        ones = 0;
        dec_stuff++;
      end else begin
        bits.push_back(s == prev);
        ones = (s == prev) ? ones + 1 : 0;
      end
      prev = s;
    end
    for (int i = 8; i + 8 <= bits.size(); i += 8) begin
      for (int j = 0; j < 8; j++) cur[j] = bits[i + j];
      dec.push_back(cur);
    end
  endtask

  task automatic verify(input string tag, input int keep, input bit abort);
    int          mism = 0;
    logic [63:0] got;
    build_exp(keep, abort);
    check({tag, " oe_cycles"}, done_cap.size(), exp_sym.size() * CPB);
    foreach (done_cap[i])
      if (i / CPB < exp_sym.size() && done_cap[i] !== exp_sym[i / CPB]) mism++;
    check({tag, " line_errs"}, mism, 0);
    if (!abort) begin
      decode();
      check({tag, " dec_count"}, dec.size(), pkt.size());
      check({tag, " dec_stuff"}, dec_stuff, exp_stuff);
      foreach (pkt[i]) begin
        got = (i < dec.size()) ? 64'(dec[i]) : 64'h100;
        check({tag, " dec_byte"}, got, pkt[i]);
      end
    end
    $display("pkt %s bytes=%0d oe_cycles=%0d stuff=%0d", tag, pkt.size(), done_cap.size(), exp_stuff);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_lp_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", tx_lp_ready, 1);
  endtask

  task automatic send_pkt(input int max_dly, input bit with_eop);
    foreach (pkt[i]) begin
      wait_ready();
      repeat ($urandom_range(max_dly, 0)) @(negedge clk);
      wait_ready();
      tx_lp_valid = 1'b1;
      tx_lp_data  = pkt[i];
      tx_lp_sop   = (i == 0);
      tx_lp_eop   = with_eop && (i == pkt.size() - 1);
      @(negedge clk);
      tx_lp_valid = 1'b0;
      tx_lp_sop   = 1'b0;
      tx_lp_eop   = 1'b0;
    end
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("pkt_done", done_cnt - start, 1);
  endtask

  task automatic rand_pkt(input int min_len, input int max_len);
    int n;
    n = $urandom_range(max_len, min_len);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int s, u0, k, m;

    repeat (3) @(negedge clk);
    check("rst dp", dp, 1);
    check("rst dm", dm, 0);
    check("rst oe", tx_oe, 0);
    check("rst underrun", tx_underrun, 0);
    check("rst ready", tx_lp_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst ready", tx_lp_ready, 1);

    pkt = {8'hD2};
    s = done_cnt; u0 = urun_cnt;
    send_pkt(0, 1'b1);
    wait_done(s);
    verify("ack", 0, 1'b0);
    check("ack oe_len", done_cap.size(), 76);
    check("ack underrun", urun_cnt - u0, 0);

    pkt = {8'hC3, 8'hFF};
    s = done_cnt;
    send_pkt(0, 1'b1);
    wait_done(s);
    verify("stuff", 0, 1'b0);
    check("stuff dut_count", dec_stuff, 1);
    check("stuff oe_len", done_cap.size(), (8 + 16 + 1 + 3) * CPB);

    pkt = {8'hC3};
    for (int i = 1; i <= 9; i++) pkt.push_back(8'(i));
    s = done_cnt; u0 = urun_cnt;
    send_pkt(20, 1'b1);
    wait_done(s);
    verify("multi", 0, 1'b0);
    check("multi underrun", urun_cnt - u0, 0);

    for (int p = 0; p < 4; p++) begin
      rand_pkt(1, 8);
      s = done_cnt; u0 = urun_cnt;
      send_pkt(20, 1'b1);
      wait_done(s);
      verify("random", 0, 1'b0);
      check("random underrun", urun_cnt - u0, 0);
    end

    pkt = {8'hC3, 8'h01};
    s = done_cnt; u0 = urun_cnt;
    send_pkt(0, 1'b0);
    wait_done(s);
    verify("underrun", 1 << 30, 1'b1);
    check("underrun pulses", urun_cnt - u0, 1);

    pkt = {8'hC3, 8'($urandom), 8'($urandom)};
    k = 24 * CPB + $urandom_range(8 * CPB - 2, 1);
    s = done_cnt;
    fork
      send_pkt(0, 1'b1);
      begin
        int n;
        n = 0;
        while (!tx_oe && n < 200) begin
          @(negedge clk);
          n++;
        end
        repeat (k) @(negedge clk);
        tx_lp_cancle = 1'b1;
        @(negedge clk);
        tx_lp_cancle = 1'b0;
      end
    join
    wait_done(s);
    verify("cancel", k / CPB + 1, 1'b1);
    m = 0;
    for (int i = (k / CPB + 1) * CPB; i < done_rdy.size(); i++) m += int'(done_rdy[i]);
    check("cancel ready_in_abort", m, 0);

    rand_pkt(2, 5);
    s = done_cnt;
    send_pkt(5, 1'b1);
    wait_done(s);
    verify("after_cancel", 0, 1'b0);

    pkt = {8'hC3, 8'($urandom), 8'($urandom)};
    send_pkt(0, 1'b1);
    repeat (10) @(negedge clk);
    check("pre_rst oe", tx_oe, 1);
    rst = 1'b1;
    #1;
    check("mid_rst dp", dp, 1);
    check("mid_rst dm", dm, 0);
    check("mid_rst oe", tx_oe, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release ready", tx_lp_ready, 1);
    check("rst_release oe", tx_oe, 0);

    rand_pkt(1, 4);
    s = done_cnt;
    send_pkt(3, 1'b1);
    wait_done(s);
    verify("after_rst", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
